reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Register-dependency scoreboard that sequences the decode stage of the in-order LoongArch pipeline. It counts in-flight writes per architectural register: increments on each issue from decode to execute, decrements on each writeback retire. It raises `stall` whenever a decoded instruction reads, or would over-commit, a register with an outstanding write. Decode drives `ds_ready_go = ~stall`; this replaces the current hard-wired `1'b1`.

## Interface
Parameters:
- `CNT_W`, default 2: width of each per-register pending counter. Maximum in-flight writes per register is 2^CNT_W-1.
- `NREG`, default 32: number of architectural registers.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `flush`  in  1  synchronous clear of all counters (pipeline squash); same effect as reset, except that `err` is kept.
- `src1_addr`  in  5  first source register of the instruction in decode (rd for branch/store, else rk).
- `src1_used`  in  1  src1 is a real read.
- `src2_addr`  in  5  second source register (rj).
- `src2_used`  in  1  src2 is a real read.
- `dst_addr`  in  5  destination of the instruction in decode (`wb_dest`).
- `dst_we`  in  1  instruction writes `dst_addr` (`wb_gr_we`).
- `ds_valid`  in  1  decode holds a valid instruction.
- `issue`  in  1  decode-to-execute handshake fires this cycle (`ds_to_es_valid & es_allowin`).
- `retire_we`  in  1  writeback register write (`wb_bus[37]`).
- `retire_addr`  in  5  writeback destination (`wb_bus[36:32]`).
- `stall`  out  1  decode must hold (ready_go low).
- `busy_vec`  out  NREG  bit i set when counter i is non-zero.
- `err`  out  1  sticky protocol-error flag.

## Operation
- Counter `cnt[i]` holds the number of issued-but-not-retired writes to register i. Register 0 is never tracked: `cnt[0]` stays 0, and issues or retires to r0 are ignored.
- Issue increment: on a cycle with `issue & dst_we & dst_addr!=0`, `cnt[dst_addr]` += 1.
- Retire decrement: on a cycle with `retire_we & retire_addr!=0`, `cnt[retire_addr]` -= 1.
- Simultaneous increment and decrement of the same register: the counter is unchanged.
- Increment and decrement of different registers in the same cycle are applied independently.
- `stall` is asserted when `ds_valid` and any of the following holds:
  - `src1_used & cnt[src1_addr]!=0`
  - `src2_used & cnt[src2_addr]!=0`
  - `dst_we & cnt[dst_addr]==2^CNT_W-1` (saturation guard)
- Sources or destination equal to r0 never cause a stall.
- Protocol errors set `err` and leave the counter unchanged:
  - `issue` while `stall` is high;
  - an increment at the maximum count;
  - a decrement at zero.
- `err` is cleared only by `reset`.
- `flush` zeroes all counters on the next edge. Any issue or retire in the same cycle as `flush` is discarded. `flush` has priority over issue and retire.
- Reset values: every `cnt` = 0, `busy_vec` = 0, `err` = 0. `stall` = 0 (it is a function of zero counters).

## Timing
- `stall` and `busy_vec` are combinational from the current counters and the decode inputs. They have zero-cycle response to decode contents.
- Counter updates take effect at the rising edge after the issue or retire cycle.
- No retire bypass. A retire in cycle N clears `stall` in cycle N+1. This matches the regfile, which writes at the edge and reads asynchronously: data written at the end of cycle N is readable in cycle N+1.
- Minimum back-to-back RAW penalty equals the EX+MEM+WB depth; the scoreboard adds no extra cycle.
- The design is a single clock domain with no multicycle paths.
- The critical path runs: counter → 32:1 mux on a source address → zero-compare → `stall`.

## Structure
- Shared package (`myCPU.h`):
  - `NREG`;
  - `REG_W`=5;
  - the `WB_BUS` field offsets used to extract `retire_we`/`retire_addr`.
- Sub-module `sb_counter`: one up/down counter with saturation and underflow detection. Its ports are `inc`, `dec`, `clr`, `cnt`, `ovf`, `unf`. It is instantiated NREG-1 times through a generate loop.
- Top level contains:
  - the 5:32 one-hot decode of `dst_addr` and `retire_addr`;
  - the two source-lookup muxes;
  - the stall logic;
  - the error OR-reduction.

## Test plan
- Reset, then idle: `stall`=0, `busy_vec`=0, `err`=0. Issue with dst r5: next cycle `busy_vec[5]`=1.
- RAW: issue `add.w r5`; the next instruction reads r5 (`src2_addr`=5). `stall`=1 until the cycle after `retire_we` with `retire_addr`=5, then `stall`=0 and `cnt[5]`=0.
- Same-cycle issue and retire of r7 with `cnt[7]`=1: `cnt[7]` stays 1 and `busy_vec[7]` stays 1. A retire alone in the next cycle gives `busy_vec[7]`=0.
- Saturation with CNT_W=2: three writes to r3 are in flight. A fourth instruction with `dst_addr`=3 sees `stall`=1 while it reads no busy source. Forcing `issue` anyway sets `err`=1 and `cnt[3]` stays 3.
- r0 and underflow:
  - issue dst r0 → `busy_vec`=0;
  - src r0 with `src1_used` → `stall`=0;
  - retire r9 at `cnt[9]`=0 → `err`=1 and `cnt[9]`=0.
- `flush` with r2, r4, r6 busy and a simultaneous issue to r8: next cycle `busy_vec`=0, and `err` keeps its prior value.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register-dependency scoreboard: register-file geometry
// and the writeback-bus fields that carry the retiring register write.
package reg_scoreboard_pkg;

   localparam int NUM_REGS   = 32;
   localparam int REG_W      = 5;

   // Writeback bus layout: {we, dest[4:0], data[31:0]}
   localparam int WB_BUS_W   = 38;
   localparam int WB_WE_BIT  = 37;
   localparam int WB_DEST_HI = 36;
   localparam int WB_DEST_LO = 32;

   function automatic logic wb_retire_we(input logic [WB_BUS_W-1:0] wb_bus);
      return wb_bus[WB_WE_BIT];
   endfunction

   function automatic logic [REG_W-1:0] wb_retire_addr(input logic [WB_BUS_W-1:0] wb_bus);
      return wb_bus[WB_DEST_HI:WB_DEST_LO];
   endfunction

endpackage

// File: rtl/reg_scoreboard_counter.sv
// One per-register pending-write counter. It refuses to wrap in either direction
// and flags the attempt instead.
module sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf,
   output logic             unf
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] r_cnt;

   // A simultaneous inc and dec cancels out, so it cannot over- or underflow.
   always_comb begin
      ovf = inc & ~dec & (r_cnt == CNT_MAX);
      unf = dec & ~inc & (r_cnt == '0);
   end

   always_ff @(posedge clk) begin
      if (clr)
         r_cnt <= '0;
      else if (inc & ~dec & ~ovf)
         r_cnt <= r_cnt + 1'b1;
      else if (dec & ~inc & ~unf)
         r_cnt <= r_cnt - 1'b1;
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage scoreboard: counts in-flight writes per architectural register
// and holds decode on RAW hazards or when a register's counter would saturate.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int CNT_W = 2,
   parameter int NREG  = NUM_REGS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic [REG_W-1:0] src1_addr,
   input  logic             src1_used,
   input  logic [REG_W-1:0] src2_addr,
   input  logic             src2_used,
   input  logic [REG_W-1:0] dst_addr,
   input  logic             dst_we,
   input  logic             ds_valid,
   input  logic             issue,
   input  logic             retire_we,
   input  logic [REG_W-1:0] retire_addr,
   output logic             stall,
   output logic [NREG-1:0]  busy_vec,
   output logic             err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NREG-1:0][CNT_W-1:0] w_cnt;
   logic [NREG-1:1]            w_inc;
   logic [NREG-1:1]            w_dec;
   logic [NREG-1:1]            w_ovf;
   logic [NREG-1:1]            w_unf;
   logic                       w_inc_en;
   logic                       w_dec_en;
   logic                       w_src1_busy;
   logic                       w_src2_busy;
   logic                       w_dst_sat;
   logic                       w_err_ev;
   logic                       r_err;

   // r0 is hard-wired: its counter is a constant zero, so reads of r0 never stall.
   assign w_cnt[0] = '0;

   assign w_src1_busy = src1_used & (w_cnt[src1_addr] != '0);
   assign w_src2_busy = src2_used & (w_cnt[src2_addr] != '0);
   assign w_dst_sat   = dst_we & (dst_addr != '0) & (w_cnt[dst_addr] == CNT_MAX);
   assign stall       = ds_valid & (w_src1_busy | w_src2_busy | w_dst_sat);

   // Flush discards any same-cycle issue or retire; a stalled issue never counts.
   assign w_inc_en = issue & ~stall & dst_we & (dst_addr != '0) & ~flush;
   assign w_dec_en = retire_we & (retire_addr != '0) & ~flush;

   genvar gi;
   generate
      for (gi = 1; gi < NREG; gi++) begin : g_reg
         assign w_inc[gi] = w_inc_en & (dst_addr == REG_W'(gi));
         assign w_dec[gi] = w_dec_en & (retire_addr == REG_W'(gi));

         sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .clr (reset | flush),
            .inc (w_inc[gi]),
            .dec (w_dec[gi]),
            .cnt (w_cnt[gi]),
            .ovf (w_ovf[gi]),
            .unf (w_unf[gi])
         );
      end
   endgenerate

   always_comb begin
      busy_vec = '0;
      for (int i = 1; i < NREG; i++)
         busy_vec[i] = |w_cnt[i];
   end

   assign w_err_ev = (issue & stall) | (|w_ovf) | (|w_unf);

   // Sticky until reset; flush squashes the pipeline but keeps the error record.
   always_ff @(posedge clk) begin
      if (reset)
         r_err <= 1'b0;
      else if (~flush & w_err_ev)
         r_err <= 1'b1;
   end

   assign err = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vector table for the multi-cycle corner
// cases, then random traffic against a per-register count model.
module tb_reg_scoreboard;

   localparam int CNT_W = 2;
   localparam int NREG  = 32;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic            clk = 1'b0;
   logic            reset, flush;
   logic [4:0]      src1_addr, src2_addr, dst_addr, retire_addr;
   logic            src1_used, src2_used, dst_we, ds_valid, issue, retire_we;
   logic            stall, err;
   logic [NREG-1:0] busy_vec;

   always #5 clk = ~clk;

   reg_scoreboard #(.CNT_W(CNT_W), .NREG(NREG)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .src1_addr   (src1_addr),
      .src1_used   (src1_used),
      .src2_addr   (src2_addr),
      .src2_used   (src2_used),
      .dst_addr    (dst_addr),
      .dst_we      (dst_we),
      .ds_valid    (ds_valid),
      .issue       (issue),
      .retire_we   (retire_we),
      .retire_addr (retire_addr),
      .stall       (stall),
      .busy_vec    (busy_vec),
      .err         (err)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %08h expected %08h", name, idx, act, exp);
      end
   endtask

   typedef struct {
      logic       rst, fl, dv, iss;
      logic [4:0] da;
      logic       dwe;
      logic [4:0] s1a;
      logic       s1u;
      logic [4:0] s2a;
      logic       s2u;
      logic       rwe;
      logic [4:0] ra;
      logic        es;
      logic [31:0] eb;
      logic        ee;
   } vec_t;

   function automatic vec_t v(input logic rst, fl, dv, iss, input logic [4:0] da, input logic dwe,
                              input logic [4:0] s1a, input logic s1u, input logic [4:0] s2a, input logic s2u,
                              input logic rwe, input logic [4:0] ra,
                              input logic es, input logic [31:0] eb, input logic ee);
      vec_t t;
      t.rst = rst; t.fl = fl; t.dv = dv; t.iss = iss; t.da = da; t.dwe = dwe;
      t.s1a = s1a; t.s1u = s1u; t.s2a = s2a; t.s2u = s2u; t.rwe = rwe; t.ra = ra;
      t.es = es; t.eb = eb; t.ee = ee;
      return t;
   endfunction

   function automatic logic [31:0] b(input int n);
      return 32'(1) << n;
   endfunction

   task automatic drive(input vec_t t);
      reset = t.rst; flush = t.fl; ds_valid = t.dv; issue = t.iss;
      dst_addr = t.da; dst_we = t.dwe; src1_addr = t.s1a; src1_used = t.s1u;
      src2_addr = t.s2a; src2_used = t.s2u; retire_we = t.rwe; retire_addr = t.ra;
   endtask

   // Reference model: plain pending-write counts per register.
   int mc[NREG];
   bit merr;

   function automatic bit m_stall();
      bit s;
      s = 0;
      if (src1_used && src1_addr != 0 && mc[src1_addr] > 0) s = 1;
      if (src2_used && src2_addr != 0 && mc[src2_addr] > 0) s = 1;
      if (dst_we && dst_addr != 0 && mc[dst_addr] == MAXC) s = 1;
      return ds_valid && s;
   endfunction

   function automatic logic [31:0] m_busy();
      logic [31:0] r;
      r = '0;
      for (int i = 1; i < NREG; i++) if (mc[i] > 0) r[i] = 1'b1;
      return r;
   endfunction

   task automatic m_update(input bit st);
      int ir, dr;
      if (reset) begin
         foreach (mc[i]) mc[i] = 0;
         merr = 0;
      end else if (flush) begin
         foreach (mc[i]) mc[i] = 0;
      end else begin
         if (issue && st) merr = 1;
         ir = (issue && !st && dst_we && dst_addr != 0) ? int'(dst_addr) : -1;
         dr = (retire_we && retire_addr != 0) ? int'(retire_addr) : -1;
         if (!(ir >= 0 && ir == dr)) begin
            if (ir >= 0) begin
               if (mc[ir] == MAXC) merr = 1; else mc[ir]++;
            end
            if (dr >= 0) begin
               if (mc[dr] == 0) merr = 1; else mc[dr]--;
            end
         end
      end
   endtask

   vec_t tbl[$];
   vec_t idle;

   initial begin
      idle = v(0,0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0,0);
      drive(idle);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      tbl.push_back(v(0,0,0,0, 0,0, 0,0, 0,0, 0,0,  0, 0, 0));              // reset state
      tbl.push_back(v(0,0,1,1, 5,1, 0,0, 0,0, 0,0,  0, 0, 0));              // issue r5
      tbl.push_back(v(0,0,0,0, 0,0, 0,0, 0,0, 0,0,  0, b(5), 0));
      tbl.push_back(v(0,0,1,0, 6,1, 0,0, 5,1, 0,0,  1, b(5), 0));           // RAW on r5
      tbl.push_back(v(0,0,1,0, 6,1, 0,0, 5,1, 1,5,  1, b(5), 0));           // retire r5, no bypass
      tbl.push_back(v(0,0,1,1, 6,1, 0,0, 5,1, 0,0,  0, 0, 0));              // released, issue r6
      tbl.push_back(v(0,0,0,0, 0,0, 0,0, 0,0, 1,6,  0, b(6), 0));
      tbl.push_back(v(0,0,1,1, 7,1, 0,0, 0,0, 0,0,  0, 0, 0));              // issue r7
      tbl.push_back(v(0,0,1,1, 7,1, 0,0, 0,0, 1,7,  0, b(7), 0));           // issue+retire r7
      tbl.push_back(v(0,0,0,0, 0,0, 0,0, 0,0, 1,7,  0, b(7), 0));           // retire r7 alone
      tbl.push_back(v(0,0,1,1, 3,1, 0,0, 0,0, 0,0,  0, 0, 0));              // r3 x3
      tbl.push_back(v(0,0,1,1, 3,1, 0,0, 0,0, 0,0,  0, b(3), 0));
      tbl.push_back(v(0,0,1,1, 3,1, 0,0, 0,0, 0,0,  0, b(3), 0));
      tbl.push_back(v(0,0,1,0, 3,1, 0,0, 0,0, 0,0,  1, b(3), 0));           // saturation guard
      tbl.push_back(v(0,0,1,1, 3,1, 0,0, 0,0, 0,0,  1, b(3), 0));           // forced issue
      tbl.push_back(v(0,0,0,0, 0,0, 0,0, 0,0, 1,3,  0, b(3), 1));           // cnt[3] must be 3
      tbl.push_back(v(0,0,0,0, 0,0, 0,0, 0,0, 1,3,  0, b(3), 1));
      tbl.push_back(v(0,0,0,0, 0,0, 0,0, 0,0, 1,3,  0, b(3), 1));
      tbl.push_back(v(1,0,0,0, 0,0, 0,0, 0,0, 0,0,  0, 0, 1));              // reset clears err
      tbl.push_back(v(0,0,1,1, 0,1, 0,0, 0,0, 0,0,  0, 0, 0));              // issue r0
      tbl.push_back(v(0,0,1,0, 0,1, 0,1, 0,0, 1,9,  0, 0, 0));              // src r0, retire r9 at 0
      tbl.push_back(v(0,0,1,1, 9,1, 0,0, 0,0, 0,0,  0, 0, 1));              // cnt[9] must be 0
      tbl.push_back(v(0,0,0,0, 0,0, 0,0, 0,0, 1,9,  0, b(9), 1));
      tbl.push_back(v(0,0,1,1, 2,1, 0,0, 0,0, 0,0,  0, 0, 1));              // r2,r4,r6 busy
      tbl.push_back(v(0,0,1,1, 4,1, 0,0, 0,0, 0,0,  0, b(2), 1));
      tbl.push_back(v(0,0,1,1, 6,1, 0,0, 0,0, 0,0,  0, b(2)|b(4), 1));
      tbl.push_back(v(0,1,1,1, 8,1, 0,0, 0,0, 1,2,  0, b(2)|b(4)|b(6), 1)); // flush + issue r8
      tbl.push_back(v(0,0,0,0, 0,0, 0,0, 0,0, 0,0,  0, 0, 1));
      tbl.push_back(v(0,0,0,0, 0,0, 0,0, 0,0, 0,0,  0, 0, 1));

      foreach (tbl[i]) begin
         drive(tbl[i]);
         @(negedge clk);
         chk("tbl_stall", i, 32'(stall), 32'(tbl[i].es));
         chk("tbl_busy",  i, busy_vec,   tbl[i].eb);
         chk("tbl_err",   i, 32'(err),   32'(tbl[i].ee));
         @(posedge clk);
         #1;
      end

      // Random traffic on a narrow register window to force collisions.
      drive(idle);
      reset = 1'b1;
      @(posedge clk);
      #1;
      foreach (mc[i]) mc[i] = 0;
      merr = 0;
      for (int c = 0; c < 3000; c++) begin
         bit st;
         reset       = ($urandom_range(0, 299) == 0);
         flush       = ($urandom_range(0, 79) == 0);
         ds_valid    = ($urandom_range(0, 3) != 0);
         src1_addr   = 5'($urandom_range(0, 7));
         src2_addr   = 5'($urandom_range(0, 7));
         dst_addr    = 5'($urandom_range(0, 7));
         src1_used   = 1'($urandom_range(0, 1));
         src2_used   = 1'($urandom_range(0, 1));
         dst_we      = ($urandom_range(0, 3) != 0);
         retire_we   = ($urandom_range(0, 2) == 0);
         retire_addr = 5'($urandom_range(0, 7));
         st          = m_stall();
         issue       = ds_valid && (st ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 1) == 1));
         @(negedge clk);
         chk("rnd_stall", c, 32'(stall), 32'(st));
         chk("rnd_busy",  c, busy_vec,   m_busy());
         chk("rnd_err",   c, 32'(err),   32'(merr));
         @(posedge clk);
         m_update(st);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
